// File: rtl/econet_tx_ctrl_if.sv
// Host and PHY signal bundle for the Econet transmit frame sequencer.
// Latency: none; this file only groups wires.
// Backpressure: none here. The PHY paces bytes through request_byte, and the host polls busy/done.
// Ports: host buffer/command strobes, line_idle from the receiver, the PHY byte handshake, status back to host.
interface econet_tx_ctrl_if;
  // host side
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clear;
  logic       send;
  logic       abort;
  logic       busy;
  logic       done;
  logic [1:0] status;
  // receiver side
  logic       line_idle;
  // PHY side
  logic [7:0] tx_byte;
  logic       start_frame;
  logic       end_frame;
  logic       request_byte;
  logic       transmitting;

  // The sequencer itself.
  modport slave (
    input  wr_en, wr_data, clear, send, abort, line_idle, request_byte, transmitting,
    output tx_byte, start_frame, end_frame, busy, done, status
  );

  // Whatever drives the sequencer (host plus PHY, or a bench).
  modport master (
    output wr_en, wr_data, clear, send, abort, line_idle, request_byte, transmitting,
    input  tx_byte, start_frame, end_frame, busy, done, status
  );
endinterface

// File: rtl/econet_tx_ctrl.sv
// Econet transmit frame sequencer. The host fills a byte buffer and sends; the block waits for an idle line, starts the PHY, feeds bytes and closes the frame.
// Latency: send->WAIT_LINE 1 cycle; start_frame IDLE_BITS+1 cycles after send on an idle line; done is registered, 1 cycle after DRAIN.
// Backpressure: the PHY pulls bytes with request_byte. The host is locked out (writes/send ignored) while busy.
// Ports: econet_clk, reset (sync, active-high), bus (econet_tx_ctrl_if.slave).
module econet_tx_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int IDLE_BITS = 15,
  parameter int TIMEOUT   = 4096
) (
  input  logic              econet_clk,
  input  logic              reset,
  econet_tx_ctrl_if.slave   bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int IDLE_W = $clog2(IDLE_BITS + 1);
  localparam int TMO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDLE_W-1:0] IDLE_TGT = IDLE_W'(IDLE_BITS);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PTR_MAX  = '1;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_EMPTY   = 2'd2;
  localparam logic [1:0] ST_ABORT   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LINE,
    S_START,
    S_SEND,
    S_DRAIN
  } state_t;

  state_t              state, state_d;
  logic [7:0]          buf_mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [IDLE_W-1:0]   idle_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                req_q;
  logic                abort_latched;
  logic                done_q;
  logic [1:0]          status_q;

  logic                done_d;
  logic [1:0]          status_d;
  logic                launch;
  logic                byte_taken;
  logic                wr_accept;

  // The buffer is only writable in IDLE. clear outranks wr_en, and the pointer saturates so
  // the length never wraps back to zero.
  assign wr_accept  = (state == S_IDLE) && !bus.clear && bus.wr_en && (wr_ptr != PTR_MAX);

  // A byte is consumed when a request ends. A request stretched by bit stuffing is still one byte.
  assign byte_taken = (state == S_SEND) && req_q && !bus.request_byte;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge econet_clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and completion decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state;
    done_d   = 1'b0;
    status_d = status_q;
    launch   = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.send) begin
          if (wr_ptr == '0) begin
            done_d   = 1'b1;
            status_d = ST_EMPTY;
          end else begin
            launch  = 1'b1;
            state_d = S_WAIT_LINE;
          end
        end
      end

      S_WAIT_LINE: begin
        // An abort cancels outright. Otherwise reaching the idle target beats a
        // timeout that lands in the same cycle.
        if (bus.abort) begin
          done_d   = 1'b1;
          status_d = ST_ABORT;
          state_d  = S_IDLE;
        end else if (idle_cnt == IDLE_TGT) begin
          state_d = S_START;
        end else if (tmo_cnt == TMO_LAST) begin
          done_d   = 1'b1;
          status_d = ST_TIMEOUT;
          state_d  = S_IDLE;
        end
      end

      S_START: begin
        if (bus.transmitting) begin
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (!bus.transmitting) begin
          state_d = S_DRAIN;
        end
      end

      S_DRAIN: begin
        done_d   = 1'b1;
        status_d = abort_latched ? ST_ABORT : ST_OK;
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointers, counters and host-visible result
  // ---------------------------------------------------------------------------
  always_ff @(posedge econet_clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      idle_cnt      <= '0;
      tmo_cnt       <= '0;
      req_q         <= 1'b0;
      abort_latched <= 1'b0;
      done_q        <= 1'b0;
      status_q      <= ST_OK;
    end else begin
      done_q   <= done_d;
      status_q <= status_d;
      req_q    <= bus.request_byte;

      if (state == S_IDLE) begin
        if (bus.clear) begin
          wr_ptr <= '0;
        end else if (wr_accept) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
      end

      if (launch) begin
        idle_cnt <= '0;
        tmo_cnt  <= '0;
      end else if (state == S_WAIT_LINE) begin
        idle_cnt <= bus.line_idle ? idle_cnt + 1'b1 : '0;
        tmo_cnt  <= tmo_cnt + 1'b1;
      end

      if (launch) begin
        rd_ptr <= '0;
      end else if (byte_taken) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      // An abort during START is held until SEND, where it forces end_frame at the
      // next byte boundary so the PHY still closes the frame with a proper flag.
      if (launch || state == S_DRAIN) begin
        abort_latched <= 1'b0;
      end else if ((state == S_START || state == S_SEND) && bus.abort) begin
        abort_latched <= 1'b1;
      end
    end
  end

  // Frame buffer: contents survive reset.
  always_ff @(posedge econet_clk) begin
    if (!reset && wr_accept) begin
      buf_mem[wr_ptr] <= bus.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.tx_byte     = buf_mem[rd_ptr];
  assign bus.start_frame = (state == S_START);
  // end_frame is combinational, so it is already valid when the PHY requests
  // the byte after the last one.
  assign bus.end_frame   = (state == S_SEND) && ((rd_ptr == wr_ptr) || abort_latched);
  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_q;
  assign bus.status      = status_q;

endmodule

// File: tb/tb_econet_tx_ctrl.sv
// Directed and randomized bench for econet_tx_ctrl with a simple PHY model.
// The model keeps the host's view of the frame as a queue. The PHY task pulls bytes and
// compares each against the queue, the end-of-frame point and the completion status.
module tb_econet_tx_ctrl;
  localparam int ADDR_W    = 4;
  localparam int IDLE_BITS = 15;
  localparam int TIMEOUT   = 64;
  localparam int MAX_LEN   = (1 << ADDR_W) - 1;

  logic econet_clk = 1'b0;
  logic reset;

  econet_tx_ctrl_if bus ();

  econet_tx_ctrl #(
    .ADDR_W   (ADDR_W),
    .IDLE_BITS(IDLE_BITS),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .econet_clk(econet_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 econet_clk = ~econet_clk;

  int checks = 0;
  int errors = 0;
  byte unsigned model_buf[$];   // bytes the host has successfully loaded

  task automatic tick();
    @(posedge econet_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    model_buf.delete();
  endtask

  task automatic host_write(input byte unsigned b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en   = 1'b0;
    if (model_buf.size() < MAX_LEN) model_buf.push_back(b);
  endtask

  task automatic send_pulse();
    bus.send = 1'b1;
    tick();
    bus.send = 1'b0;
  endtask

  task automatic load_random(input int len);
    host_clear();
    for (int i = 0; i < len; i++) host_write(8'($urandom));
  endtask

  // Sends the current buffer through a PHY model. stuff_idx selects the request stretched by
  // bit stuffing. abort_after >= 0 pulses abort in the gap after that byte. busy_poke tries
  // a write and a send while the frame is in flight.
  task automatic run_frame(input int stuff_idx, input int stuff_len, input int abort_after,
                           input bit busy_poke, input logic [1:0] exp_status);
    int n;
    int exp_n;
    int end_at;
    int hold;
    bit ended;
    exp_n = model_buf.size();
    if (abort_after >= 0 && abort_after + 1 < exp_n) exp_n = abort_after + 1;

    send_pulse();
    n = 0;
    while (!bus.start_frame && n < 200) begin
      tick();
      n++;
    end
    chk("start_latency", n, IDLE_BITS + 1);
    repeat (2) tick();
    chk("start_held", bus.start_frame, 1'b1);
    bus.transmitting = 1'b1;
    tick();
    chk("start_dropped", bus.start_frame, 1'b0);
    repeat (8) tick();   // opening flag

    ended  = 1'b0;
    end_at = -1;
    for (int k = 0; k <= MAX_LEN + 1 && !ended; k++) begin
      bus.request_byte = 1'b1;
      if (bus.end_frame) begin
        ended  = 1'b1;
        end_at = k;
        tick();
        bus.request_byte = 1'b0;
      end else begin
        chk("tx_byte", bus.tx_byte, (k < model_buf.size()) ? model_buf[k] : 8'h00);
        hold = (k == stuff_idx) ? stuff_len : 1;
        for (int h = 1; h < hold; h++) begin
          tick();
          chk("tx_byte_stable", bus.tx_byte, model_buf[k]);
        end
        tick();
        bus.request_byte = 1'b0;
        if (k == abort_after) begin
          bus.abort = 1'b1;
          tick();
          bus.abort = 1'b0;
        end
        if (busy_poke && k == 0) begin
          bus.wr_en   = 1'b1;
          bus.wr_data = 8'hA5;
          bus.send    = 1'b1;
          tick();
          bus.wr_en   = 1'b0;
          bus.send    = 1'b0;
        end
        repeat ($urandom_range(4, 8)) tick();
      end
    end
    chk("end_frame_request", end_at, exp_n);

    repeat (8) tick();   // closing flag
    bus.transmitting = 1'b0;
    tick();
    chk("drain_busy", bus.busy, 1'b1);
    chk("drain_no_done", bus.done, 1'b0);
    tick();
    chk("done_pulse", bus.done, 1'b1);
    chk("busy_with_done", bus.busy, 1'b0);
    chk("frame_status", bus.status, exp_status);
    tick();
    chk("done_one_cycle", bus.done, 1'b0);
  endtask

  initial begin
    int n;
    bit saw_start;
    int len;

    reset            = 1'b1;
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.clear        = 1'b0;
    bus.send         = 1'b0;
    bus.abort        = 1'b0;
    bus.line_idle    = 1'b1;
    bus.request_byte = 1'b0;
    bus.transmitting = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_start_frame", bus.start_frame, 1'b0);
    chk("rst_end_frame", bus.end_frame, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_status", bus.status, 2'd0);

    // Abort in IDLE does nothing
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("idle_abort_done", bus.done, 1'b0);
    chk("idle_abort_busy", bus.busy, 1'b0);

    // Basic 3-byte frame; write and send while busy must be ignored
    host_clear();
    host_write(8'h7E);
    host_write(8'h01);
    host_write(8'hFF);
    run_frame(-1, 1, -1, 1'b1, 2'd0);

    // Stuffing stretches the request for 0x3F; exactly one byte is consumed
    host_clear();
    host_write(8'h3F);
    host_write(8'($urandom));
    host_write(8'($urandom));
    run_frame(0, 3, -1, 1'b0, 2'd0);

    // Randomized frames
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, MAX_LEN);
      load_random(len);
      run_frame($urandom_range(0, len - 1), $urandom_range(2, 4), -1, 1'b0, 2'd0);
    end

    // Writes past capacity saturate at MAX_LEN
    load_random(MAX_LEN + 5);
    chk("model_saturated", model_buf.size(), MAX_LEN);
    run_frame(-1, 1, -1, 1'b0, 2'd0);

    // Line never idle long enough: timeout
    send_pulse();
    n         = 0;
    saw_start = 1'b0;
    while (!bus.done && n < 200) begin
      bus.line_idle = ((n % 10) != 9);
      if (bus.start_frame) saw_start = 1'b1;
      tick();
      n++;
    end
    bus.line_idle = 1'b1;
    chk("timeout_latency", n, TIMEOUT);
    chk("timeout_no_start", saw_start, 1'b0);
    chk("timeout_status", bus.status, 2'd1);
    chk("timeout_busy", bus.busy, 1'b0);

    // clear beats wr_en, then send with an empty buffer
    bus.clear = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h55;
    tick();
    bus.clear = 1'b0;
    bus.wr_en = 1'b0;
    model_buf.delete();
    send_pulse();
    chk("empty_done", bus.done, 1'b1);
    chk("empty_status", bus.status, 2'd2);
    chk("empty_busy", bus.busy, 1'b0);
    chk("empty_no_start", bus.start_frame, 1'b0);
    tick();
    chk("empty_done_clear", bus.done, 1'b0);

    // Abort while waiting for the line
    host_write(8'h11);
    host_write(8'h22);
    bus.line_idle = 1'b0;
    send_pulse();
    repeat (5) tick();
    chk("wait_busy", bus.busy, 1'b1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.line_idle = 1'b1;
    chk("wait_abort_done", bus.done, 1'b1);
    chk("wait_abort_status", bus.status, 2'd3);
    chk("wait_abort_busy", bus.busy, 1'b0);

    // 10-byte frame aborted during byte 3: 4 bytes go out, then end_frame
    load_random(10);
    run_frame(-1, 1, 3, 1'b0, 2'd3);

    // Reset in the middle of SEND
    load_random(5);
    send_pulse();
    n = 0;
    while (!bus.start_frame && n < 200) begin
      tick();
      n++;
    end
    chk("rst_test_start", bus.start_frame, 1'b1);
    bus.transmitting = 1'b1;
    repeat (9) tick();
    bus.request_byte = 1'b1;
    tick();
    chk("rst_test_busy", bus.busy, 1'b1);
    reset = 1'b1;
    tick();
    chk("midrst_start_frame", bus.start_frame, 1'b0);
    chk("midrst_end_frame", bus.end_frame, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_done", bus.done, 1'b0);
    chk("midrst_status", bus.status, 2'd0);
    reset = 1'b0;
    bus.request_byte = 1'b0;
    bus.transmitting = 1'b0;
    model_buf.delete();
    tick();
    chk("post_rst_done", bus.done, 1'b0);

    // A clean frame after the abort and reset reports ok again
    load_random(4);
    run_frame(2, 2, -1, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute backstop so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/econet_tx_ctrl.md
Name: econet_tx_ctrl

Overview:
Frame-level sequencer for the Econet transmit PHY. The host loads a frame into a local byte buffer and issues a send command. The block then waits for the line to be idle, starts the PHY, supplies bytes on the PHY's byte-request handshake, terminates the frame with end_frame, and reports completion or error. It sits between the host register interface and the transmit PHY, in the same econet_clk domain.

Parameters:
ADDR_W, 8, buffer address width; capacity 2**ADDR_W bytes (frame length 1..2**ADDR_W-1).
IDLE_BITS, 15, consecutive econet_clk cycles line_idle must be high before start.
TIMEOUT, 4096, econet_clk cycles allowed in WAIT_LINE before giving up.

Ports:
econet_clk  in  1  Econet bit clock; this block uses the rising edge only.
reset  in  1  synchronous, active-high.
wr_en  in  1  host buffer write strobe.
wr_data  in  8  host byte, written at wr_ptr.
clear  in  1  host: zero wr_ptr/length.
send  in  1  host: start frame of current length (one-cycle pulse).
abort  in  1  host: truncate or cancel current frame (pulse).
line_idle  in  1  receiver reports the line carries no traffic.
tx_byte  out  8  byte to PHY (buf[rd_ptr]).
start_frame  out  1  to PHY.
end_frame  out  1  to PHY.
request_byte  in  1  from PHY; high means the PHY loads tx_byte on the next falling edge.
transmitting  in  1  from PHY.
busy  out  1  high in any state except IDLE.
done  out  1  one-cycle pulse at frame end (success or error).
status  out  2  0=ok, 1=line timeout, 2=empty frame, 3=aborted; valid from the done pulse until the next send.

Behaviour:
- Reset: state IDLE; wr_ptr=0, rd_ptr=0, counters=0; start_frame=0, end_frame=0, busy=0, done=0, status=0. Buffer contents are not reset.
- Buffer writes: wr_en writes buf[wr_ptr] and increments wr_ptr (length=wr_ptr).
  - Ignored when busy=1 or when wr_ptr==2**ADDR_W-1 (saturates, no wrap).
  - clear has priority over wr_en and is ignored while busy.
- States:
  - IDLE: on send with length==0: pulse done, status=2, stay IDLE. On send otherwise: rd_ptr=0, idle_cnt=0, tmo_cnt=0, go WAIT_LINE.
  - WAIT_LINE: idle_cnt increments while line_idle=1 and clears to 0 when line_idle=0. tmo_cnt increments every cycle. When idle_cnt reaches IDLE_BITS, go START. If instead tmo_cnt reaches TIMEOUT-1, pulse done, status=1, go IDLE. If both happen in the same cycle, START wins. abort: done, status=3, IDLE.
  - START: start_frame=1. Hold it until a cycle where transmitting=1, then clear start_frame and go SEND.
  - SEND: tx_byte=buf[rd_ptr], held stable while request_byte=1.
    - rd_ptr increments once, on the first cycle where request_byte=0 after a cycle where it was 1 (falling-edge detect via registered copy).
    - A long request caused by bit stuffing therefore consumes only one byte.
    - The first request, at the end of the opening flag, loads byte 0.
    - end_frame = (rd_ptr==length) or abort_latched; combinational, so it is valid while the PHY requests the byte after the last one.
    - abort in SEND sets abort_latched. The frame truncates at the next byte boundary with a correct closing flag.
    - When transmitting falls to 0, go DRAIN.
  - DRAIN: one cycle. Pulse done; status=3 if abort_latched, else 0. Clear abort_latched, go IDLE.
- send while busy is ignored. abort in IDLE is ignored. abort in START: latched, applied in SEND.
- Latency:
  - send to WAIT_LINE: 1 cycle.
  - Line idle throughout: start_frame asserted IDLE_BITS+1 cycles after send.
- reset mid-frame: returns to IDLE immediately, drops start_frame/end_frame, no done pulse. The PHY shares the same reset, so the line returns to idle.
- rd_ptr and wr_ptr are ADDR_W bits; all comparisons are unsigned.

Test Plan:
- Load 3 bytes 0x7E,0x01,0xFF; line_idle=1; send -> start_frame at cycle 16. PHY model loads 0x7E,0x01,0xFF in order. end_frame is high on the 4th request. done pulses with status=0; busy falls the same cycle as done.
- Byte 0x3F (stuffing stretches request_byte) -> rd_ptr advances exactly once; following byte is correct.
- line_idle toggles 0 every 10 cycles, TIMEOUT=64 -> no start_frame; done pulses at cycle 64 after send, status=1.
- send with length 0 -> done next cycle, status=2, start_frame never asserted.
- 10-byte frame, abort during byte 3 -> end_frame on the next request; 4 bytes sent; done with status=3.
- wr_en and send while busy -> both ignored. Reset asserted mid-SEND -> all outputs at reset values on the next cycle.
